// File: rtl/prbs8_checker_if.sv
// Receive-side bus of the PRBS8 checker: word stream and control in, status out.
interface prbs8_checker_if #(
  parameter int ERR_W = 16
);
  logic [7:0]       data_in;
  logic             data_valid;
  logic             clear_cnt;
  logic             locked;
  logic             error_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output data_in, data_valid, clear_cnt,
    input  locked, error_pulse, err_count
  );

  modport slave (
    input  data_in, data_valid, clear_cnt,
    output locked, error_pulse, err_count
  );
endinterface

// File: rtl/prbs8_checker.sv
// PRBS8 stream checker: seeds from received words, locks after LOCK_COUNT hits,
// then free-runs its prediction and counts mismatches; registered outputs, 1-cycle latency.
module prbs8_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  prbs8_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  state_t           state_q, state_d;
  logic [7:0]       pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    logic [7:0] n;
    n[0] = s[7];
    n[1] = s[3];
    n[2] = s[6] ^ s[7];
    n[3] = s[2] ^ s[7];
    n[4] = s[0] ^ s[7];
    n[5] = ~(s[4] & s[7]);
    n[6] = s[1];
    n[7] = s[5];
    return n;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pred_q      <= 8'h00;
      match_q     <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bus.data_valid) begin
      unique case (state_q)
        IDLE: begin
          pred_d  = nxt(bus.data_in);
          match_d = 4'd0;
          state_d = SEARCH;
        end
        SEARCH: begin
          pred_d = nxt(bus.data_in);
          if (bus.data_in == pred_q) begin
            match_d = match_q + 4'd1;
            if (match_d == LOCK_C) begin
              state_d  = LOCKED;
              miss_d   = 4'd0;
              locked_d = 1'b1;
            end
          end else begin
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          // Free-run from the prediction so a single corrupted word costs one error.
          pred_d = nxt(pred_q);
          if (bus.data_in == pred_q) begin
            miss_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
            miss_d = miss_q + 4'd1;
            if (miss_d == LOSS_C) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              match_d  = 4'd0;
              pred_d   = nxt(bus.data_in);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bus.clear_cnt) err_cnt_d = '0;
  end

  assign bus.locked      = locked_q;
  assign bus.error_pulse = err_pulse_q;
  assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Drives two checker instances (default, and ERR_W=4/LOSS_COUNT=15) with the same
// directed stream; a behavioural model feeds an expected-result queue per edge.
module tb_prbs8_checker;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  prbs8_checker_if #(.ERR_W(16)) bus_a();
  prbs8_checker_if #(.ERR_W(4))  bus_b();

  prbs8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a.slave)
  );
  prbs8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .ERR_W(4)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b.slave)
  );

  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int         m_st[2];
  logic [7:0] m_pred[2];
  int         m_mr[2];
  int         m_ms[2];
  logic       m_lk[2];
  logic       m_ep[2];
  int         m_ec[2];
  int         p_lock[2] = '{4, 4};
  int         p_loss[2] = '{3, 15};
  int         p_max[2]  = '{65535, 15};

  function automatic logic [7:0] ref_nxt(input logic [7:0] s);
    return {s[5], s[1], ~(s[4] & s[7]), s[0] ^ s[7], s[2] ^ s[7], s[6] ^ s[7], s[3], s[7]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_pred[i] = 8'h00; m_mr[i] = 0; m_ms[i] = 0;
      m_lk[i] = 1'b0; m_ep[i] = 1'b0; m_ec[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [7:0] d, input logic clr);
    m_ep[i] = 1'b0;
    if (v) begin
      if (m_st[i] == 0) begin
        m_pred[i] = ref_nxt(d); m_mr[i] = 0; m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        if (d == m_pred[i]) begin
          m_mr[i]++;
          if (m_mr[i] == p_lock[i]) begin m_st[i] = 2; m_ms[i] = 0; m_lk[i] = 1'b1; end
        end else m_mr[i] = 0;
        m_pred[i] = ref_nxt(d);
      end else begin
        if (d == m_pred[i]) begin
          m_ms[i] = 0;
          m_pred[i] = ref_nxt(m_pred[i]);
        end else begin
          m_ep[i] = 1'b1;
          if (m_ec[i] < p_max[i]) m_ec[i]++;
          m_ms[i]++;
          if (m_ms[i] == p_loss[i]) begin
            m_st[i] = 1; m_lk[i] = 1'b0; m_mr[i] = 0; m_pred[i] = ref_nxt(d);
          end else m_pred[i] = ref_nxt(m_pred[i]);
        end
      end
    end
    if (clr) m_ec[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    exp_t e;
    bus_a.data_valid = v; bus_a.data_in = d; bus_a.clear_cnt = clr;
    bus_b.data_valid = v; bus_b.data_in = d; bus_b.clear_cnt = clr;
    for (int i = 0; i < 2; i++) begin
      model_step(i, v, d, clr);
      e.lk = m_lk[i]; e.ep = m_ep[i]; e.ec = 16'(m_ec[i]);
      sb.push_back(e);
    end
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    chk("a_locked", {15'd0, bus_a.locked}, {15'd0, e.lk});
    chk("a_pulse",  {15'd0, bus_a.error_pulse}, {15'd0, e.ep});
    chk("a_count",  bus_a.err_count, e.ec);
    e = sb.pop_front();
    chk("b_locked", {15'd0, bus_b.locked}, {15'd0, e.lk});
    chk("b_pulse",  {15'd0, bus_b.error_pulse}, {15'd0, e.ep});
    chk("b_count",  {12'd0, bus_b.err_count}, e.ec);
  endtask

  task automatic do_reset();
    bus_a.data_valid = 1'b0; bus_b.data_valid = 1'b0;
    bus_a.clear_cnt  = 1'b0; bus_b.clear_cnt  = 1'b0;
    rst_in = 1'b1;
    model_reset();
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  logic [7:0] seq[5] = '{8'hFF, 8'hC3, 8'h69, 8'hB6, 8'hD5};
  logic [7:0] g;

  initial begin
    bus_a.data_in = 8'h00; bus_a.data_valid = 1'b0; bus_a.clear_cnt = 1'b0;
    bus_b.data_in = 8'h00; bus_b.data_valid = 1'b0; bus_b.clear_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_locked", {15'd0, bus_a.locked}, 16'd0);
    chk("rst_pulse",  {15'd0, bus_a.error_pulse}, 16'd0);
    chk("rst_count",  bus_a.err_count, 16'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Lock on back-to-back words.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      chk("lock_point", {15'd0, bus_a.locked}, (k == 4) ? 16'd1 : 16'd0);
    end
    chk("lock_nocount", bus_a.err_count, 16'd0);

    // One corrupted word, then the correct sequence resumes.
    g = ref_nxt(8'hD5);
    step(1'b1, g ^ 8'h01, 1'b0);
    chk("single_pulse", {15'd0, bus_a.error_pulse}, 16'd1);
    chk("single_count", bus_a.err_count, 16'd1);
    chk("single_lock",  {15'd0, bus_a.locked}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      g = ref_nxt(g);
      step(1'b1, g, 1'b0);
      chk("after_err_pulse", {15'd0, bus_a.error_pulse}, 16'd0);
    end
    chk("after_err_count", bus_a.err_count, 16'd1);

    // Clear on a correct word, then three unpredicted words drop lock.
    g = ref_nxt(g);
    step(1'b1, g, 1'b1);
    chk("clear_count", bus_a.err_count, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h00, 1'b0);
      chk("loss_pulse", {15'd0, bus_a.error_pulse}, 16'd1);
      chk("loss_lock",  {15'd0, bus_a.locked}, (k == 2) ? 16'd0 : 16'd1);
    end
    chk("loss_count", bus_a.err_count, 16'd3);
    g = 8'h5A;
    step(1'b1, g, 1'b0);
    for (int k = 0; k < 4; k++) begin
      g = ref_nxt(g);
      step(1'b1, g, 1'b0);
      chk("relock", {15'd0, bus_a.locked}, (k == 3) ? 16'd1 : 16'd0);
    end

    // Same lock stream with 3-cycle gaps between words.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 8'hA5, 1'b0);
        chk("gap_lock", {15'd0, bus_a.locked}, (k == 4) ? 16'd1 : 16'd0);
      end
    end
    chk("gap_count", bus_a.err_count, 16'd0);

    // Saturation and clear-vs-increment on the ERR_W=4, LOSS_COUNT=15 instance.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, seq[k], 1'b0);
    chk("sat_locked", {15'd0, bus_b.locked}, 16'd1);
    g = ref_nxt(8'hD5);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, ~g, 1'b0);
      g = ref_nxt(g);
    end
    step(1'b1, g, 1'b0);
    g = ref_nxt(g);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, ~g, 1'b0);
      g = ref_nxt(g);
    end
    chk("sat_count", {12'd0, bus_b.err_count}, 16'h000F);
    chk("sat_still_locked", {15'd0, bus_b.locked}, 16'd1);
    step(1'b1, ~g, 1'b1);
    g = ref_nxt(g);
    chk("clr_pulse", {15'd0, bus_b.error_pulse}, 16'd1);
    chk("clr_count", {12'd0, bus_b.err_count}, 16'd0);
    step(1'b1, ~g, 1'b0);
    chk("post_clr_count", {12'd0, bus_b.err_count}, 16'd1);

    // Asynchronous reset mid-cycle while locked with a nonzero count.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, seq[k], 1'b0);
    step(1'b1, 8'h00, 1'b0);
    chk("pre_arst_count", bus_a.err_count, 16'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_locked_a", {15'd0, bus_a.locked}, 16'd0);
    chk("arst_count_a",  bus_a.err_count, 16'd0);
    chk("arst_locked_b", {15'd0, bus_b.locked}, 16'd0);
    chk("arst_count_b",  {12'd0, bus_b.err_count}, 16'd0);
    bus_a.data_valid = 1'b0; bus_b.data_valid = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      chk("arst_relock", {15'd0, bus_a.locked}, (k == 4) ? 16'd1 : 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
